// File: rtl/mem_stage.sv
// MIPS memory-access stage: EX/MEM pipeline register, word-organised data memory
// with byte/halfword store merging, and load extraction. Optional macro DM_DISPLAY_EN
// logs each committed store.
module mem_stage #(
  parameter int DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_E,
  input  logic [31:0] PC_E,
  input  logic [31:0] ALUout_E,
  input  logic [31:0] WriteData_E,
  input  logic [4:0]  WRegAdd_E,
  input  logic        RegWrite_E,
  input  logic [1:0]  Mem2Reg_E,
  input  logic        ForwardRTM,
  input  logic [31:0] result_W,
  output logic [31:0] instr_M,
  output logic [31:0] PC_M,
  output logic [31:0] ALUout_M,
  output logic [31:0] WriteData_M,
  output logic [4:0]  WRegAdd_M,
  output logic        RegWrite_M,
  output logic [1:0]  Mem2Reg_M,
  output logic [31:0] ReadData_M
);

  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;

  logic [31:0] mem [0:DM_WORDS-1];
  logic [9:0]  a;
  logic [5:0]  op;
  logic [31:0] sd;
  logic [31:0] w;
  logic [31:0] merged_word;
  logic        store_en;
  logic [15:0] half;
  logic [7:0]  byte_sel;

  assign a  = ALUout_M[11:2];
  assign op = instr_M[31:26];
  // W-to-M forwarding of the store data, no stall required
  assign sd = ForwardRTM ? result_W : WriteData_M;
  assign w  = mem[a];

  always_comb begin
    merged_word = w;
    store_en    = 1'b0;
    case (op)
      OP_SW: begin
        merged_word = sd;
        store_en    = 1'b1;
      end
      OP_SH: begin
        store_en = 1'b1;
        if (ALUout_M[1]) merged_word[31:16] = sd[15:0];
        else             merged_word[15:0]  = sd[15:0];
      end
      OP_SB: begin
        store_en = 1'b1;
        case (ALUout_M[1:0])
          2'd0:    merged_word[7:0]   = sd[7:0];
          2'd1:    merged_word[15:8]  = sd[7:0];
          2'd2:    merged_word[23:16] = sd[7:0];
          default: merged_word[31:24] = sd[7:0];
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    half     = ALUout_M[1] ? w[31:16] : w[15:0];
    byte_sel = w[8*ALUout_M[1:0] +: 8];
    case (op)
      OP_LH:   ReadData_M = {{16{half[15]}}, half};
      OP_LHU:  ReadData_M = {16'h0, half};
      OP_LB:   ReadData_M = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ReadData_M = {24'h0, byte_sel};
      default: ReadData_M = w;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_M     <= '0;
      PC_M        <= '0;
      ALUout_M    <= '0;
      WriteData_M <= '0;
      WRegAdd_M   <= '0;
      RegWrite_M  <= 1'b0;
      Mem2Reg_M   <= '0;
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    end else begin
      instr_M     <= instr_E;
      PC_M        <= PC_E;
      ALUout_M    <= ALUout_E;
      WriteData_M <= WriteData_E;
      WRegAdd_M   <= WRegAdd_E;
      RegWrite_M  <= RegWrite_E;
      Mem2Reg_M   <= Mem2Reg_E;
      if (store_en) begin
        mem[a] <= merged_word;
`ifdef DM_DISPLAY_EN
        $display("%d@%h: *%h <= %h", $time, PC_M, {ALUout_M[31:2], 2'b00}, merged_word);
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a reference word model plus an expected-load
// queue checked when each load occupies the M stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_E, PC_E, ALUout_E, WriteData_E, result_W;
  logic [4:0]  WRegAdd_E;
  logic        RegWrite_E, ForwardRTM;
  logic [1:0]  Mem2Reg_E;
  logic [31:0] instr_M, PC_M, ALUout_M, WriteData_M, ReadData_M;
  logic [4:0]  WRegAdd_M;
  logic        RegWrite_M;
  logic [1:0]  Mem2Reg_M;

  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_ADD = 6'b000000;

  logic [31:0] model [0:1023];
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.DM_WORDS(1024)) dut (
    .clk(clk), .reset(reset),
    .instr_E(instr_E), .PC_E(PC_E), .ALUout_E(ALUout_E), .WriteData_E(WriteData_E),
    .WRegAdd_E(WRegAdd_E), .RegWrite_E(RegWrite_E), .Mem2Reg_E(Mem2Reg_E),
    .ForwardRTM(ForwardRTM), .result_W(result_W),
    .instr_M(instr_M), .PC_M(PC_M), .ALUout_M(ALUout_M), .WriteData_M(WriteData_M),
    .WRegAdd_M(WRegAdd_M), .RegWrite_M(RegWrite_M), .Mem2Reg_M(Mem2Reg_M),
    .ReadData_M(ReadData_M)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ld_value(input logic [5:0] op, input logic [31:0] addr);
    logic [31:0] wd;
    logic [15:0] h;
    logic [7:0]  b;
    wd = model[addr[11:2]];
    h  = addr[1] ? wd[31:16] : wd[15:0];
    case (addr[1:0])
      2'd0: b = wd[7:0];
      2'd1: b = wd[15:8];
      2'd2: b = wd[23:16];
      default: b = wd[31:24];
    endcase
    case (op)
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h0, b};
      default: return wd;
    endcase
  endfunction

  task automatic st_model(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sd);
    logic [31:0] wd;
    wd = model[addr[11:2]];
    if (op == OP_SW) wd = sd;
    else if (op == OP_SH) begin
      if (addr[1]) wd[31:16] = sd[15:0];
      else         wd[15:0]  = sd[15:0];
    end else begin
      case (addr[1:0])
        2'd0: wd[7:0]   = sd[7:0];
        2'd1: wd[15:8]  = sd[7:0];
        2'd2: wd[23:16] = sd[7:0];
        default: wd[31:24] = sd[7:0];
      endcase
    end
    model[addr[11:2]] = wd;
  endtask

  // Drive one instruction from EX, advance it into M, then model/check it there.
  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic fwd, input logic [31:0] resw, input string name);
    logic [31:0] exp;
    instr_E     = {op, 26'($urandom)};
    PC_E        = $urandom;
    ALUout_E    = addr;
    WriteData_E = wdata;
    WRegAdd_E   = 5'($urandom);
    RegWrite_E  = 1'($urandom);
    Mem2Reg_E   = 2'($urandom);
    @(posedge clk);
    #1;
    ForwardRTM = fwd;
    result_W   = resw;
    if (op == OP_SW || op == OP_SH || op == OP_SB) begin
      st_model(op, addr, fwd ? resw : wdata);
    end else begin
      exp_q.push_back(ld_value(op, addr));
      #1;
      exp = exp_q.pop_front();
      n_checks++;
      if (ReadData_M !== exp) begin
        n_fail++;
        $display("FAIL %s: ReadData_M=%h expected %h", name, ReadData_M, exp);
      end
    end
  endtask

  task automatic check_m_zero(input string name);
    n_checks++;
    if ({instr_M, PC_M, ALUout_M, WriteData_M, WRegAdd_M, RegWrite_M, Mem2Reg_M} !== '0) begin
      n_fail++;
      $display("FAIL %s: instr_M=%h PC_M=%h ALUout_M=%h WriteData_M=%h WRegAdd_M=%0d RegWrite_M=%b Mem2Reg_M=%0d expected all 0",
               name, instr_M, PC_M, ALUout_M, WriteData_M, WRegAdd_M, RegWrite_M, Mem2Reg_M);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_E = '0; PC_E = '0; ALUout_E = '0; WriteData_E = '0;
    WRegAdd_E = '0; RegWrite_E = 1'b0; Mem2Reg_E = '0;
    ForwardRTM = 1'b0; result_W = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 1024; i++) model[i] = '0;
    check_m_zero("reset_regs");
    n_checks++;
    if (ReadData_M !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem0: ReadData_M=%h expected 00000000", ReadData_M);
    end
  endtask

  task automatic test_plan_sequence();
    issue(OP_SW,  32'h10, 32'h12345678, 1'b0, 32'h0, "sw_then_lw");
    issue(OP_LW,  32'h10, 32'h0, 1'b0, 32'h0, "lw_0x10");
    issue(OP_SB,  32'h11, 32'h000000AB, 1'b0, 32'h0, "sb");
    issue(OP_LBU, 32'h11, 32'h0, 1'b0, 32'h0, "lbu_0x11");
    issue(OP_LW,  32'h10, 32'h0, 1'b0, 32'h0, "lw_after_sb");
    issue(OP_LB,  32'h11, 32'h0, 1'b0, 32'h0, "lb_0x11");
    issue(OP_SH,  32'h12, 32'h00008001, 1'b0, 32'h0, "sh");
    issue(OP_LH,  32'h12, 32'h0, 1'b0, 32'h0, "lh_0x12");
    issue(OP_LHU, 32'h12, 32'h0, 1'b0, 32'h0, "lhu_0x12");
    issue(OP_LW,  32'h10, 32'h0, 1'b0, 32'h0, "lw_after_sh");
    n_checks++;
    if (model[4] !== 32'h8001AB78) begin
      n_fail++;
      $display("FAIL plan_model: model word=%h expected 8001ab78", model[4]);
    end
  endtask

  task automatic test_forwarding();
    issue(OP_SW, 32'h20, 32'h0, 1'b1, 32'hDEADBEEF, "sw_fwd");
    issue(OP_LW, 32'h20, 32'h0, 1'b0, 32'h0, "lw_fwd");
    issue(OP_SB, 32'h23, 32'h11111111, 1'b1, 32'h000000C3, "sb_fwd");
    issue(OP_LW, 32'h20, 32'h0, 1'b0, 32'h0, "lw_sb_fwd");
    issue(OP_LW, 32'hFFFFF020, 32'h0, 1'b0, 32'h0, "lw_high_bits_ignored");
    issue(OP_ADD, 32'h20, 32'h55555555, 1'b0, 32'h0, "non_mem_reads_word");
    issue(OP_ADD, 32'h20, 32'h0, 1'b0, 32'h0, "non_mem_no_write");
  endtask

  task automatic test_passthrough();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] ins, pc, alu, wd;
      logic [4:0]  wr;
      logic        rw;
      logic [1:0]  m2r;
      ins = {OP_ADD, 26'($urandom)}; pc = $urandom; alu = (k == 0) ? 32'h7 : $urandom;
      wd = $urandom; wr = (k == 0) ? 5'd9 : 5'($urandom);
      rw = (k == 0) ? 1'b1 : 1'($urandom); m2r = 2'($urandom);
      instr_E = ins; PC_E = pc; ALUout_E = alu; WriteData_E = wd;
      WRegAdd_E = wr; RegWrite_E = rw; Mem2Reg_E = m2r;
      @(posedge clk);
      #1;
      n_checks++;
      if ({instr_M, PC_M, ALUout_M, WriteData_M, WRegAdd_M, RegWrite_M, Mem2Reg_M}
          !== {ins, pc, alu, wd, wr, rw, m2r}) begin
        n_fail++;
        $display("FAIL passthrough%0d: got %h/%h/%h/%h/%0d/%b/%0d expected %h/%h/%h/%h/%0d/%b/%0d", k,
                 instr_M, PC_M, ALUout_M, WriteData_M, WRegAdd_M, RegWrite_M, Mem2Reg_M,
                 ins, pc, alu, wd, wr, rw, m2r);
      end
    end
  endtask

  task automatic test_reset_over_store();
    issue(OP_SW, 32'h30, 32'hCAFEF00D, 1'b0, 32'h0, "sw_before_reset");
    reset = 1'b1;
    instr_E = '0; PC_E = '0; ALUout_E = '0; WriteData_E = '0;
    WRegAdd_E = '0; RegWrite_E = 1'b0; Mem2Reg_E = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 1024; i++) model[i] = '0;
    check_m_zero("reset_over_store_regs");
    issue(OP_LW, 32'h30, 32'h0, 1'b0, 32'h0, "lw_after_reset_store_dropped");
    issue(OP_LW, 32'h10, 32'h0, 1'b0, 32'h0, "lw_after_reset_cleared");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [8];
    ops = '{OP_SW, OP_SH, OP_SB, OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    for (int k = 0; k < 60; k++) begin
      logic [5:0]  op;
      logic [31:0] addr;
      op   = ops[$urandom_range(0, 7)];
      addr = {($urandom_range(0, 1) == 1) ? 20'($urandom) : 20'h0, 12'($urandom_range(0, 63))};
      issue(op, addr, $urandom, 1'($urandom), $urandom, "random_op");
    end
  endtask

  initial begin
    test_reset();
    test_plan_sequence();
    test_forwarding();
    test_passthrough();
    test_reset_over_store();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
